// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM traffic generator.
package sdram_pkg;

  typedef enum logic {
    TG_PAIRED     = 1'b0,
    TG_SEQUENTIAL = 1'b1
  } tg_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
    StDone
  } tg_state_e;

  localparam logic [31:0] LFSR_POLY32 = 32'h8020_0003;

endpackage

// File: rtl/sdram_lfsr.sv
// Right-shifting Galois LFSR with synchronous reload and single-step advance.
module sdram_lfsr
  import sdram_pkg::*;
#(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (step) begin
      value <= value[0] ? ((value >> 1) ^ POLY) : (value >> 1);
    end
  end

endmodule

// File: rtl/sdram_traffic_gen.sv
// Write/read-back traffic generator and checker acting as manager on the ctrl_if handshake.
module sdram_traffic_gen
  import sdram_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            NUM_TXN        = 1024,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK      = ADDR_WIDTH'(32'h00FF_FFFC),
  parameter logic [31:0]            ADDR_SEED      = 32'hACE1_0001,
  parameter logic [31:0]            DATA_SEED      = 32'h1234_5679,
  parameter int unsigned            TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  cmd_wr,
  output logic                  cmd_rd,
  input  logic                  cmd_rdy,
  input  logic                  wvalid,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam int unsigned     IDX_W      = $clog2(NUM_TXN + 1);
  localparam int unsigned     TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned     BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TXN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  tg_state_e               state_q;
  tg_mode_e                mode_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    pend_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [31:0]             addr_val;
  logic [31:0]             data_val;

  logic in_txn, accept, last, seq, wr_fin, rd_fin, mism, tmo_hit, go;
  logic addr_load, addr_step, data_load, data_step;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [15:0]           err_next;

  function automatic logic [ADDR_WIDTH-1:0] seq_addr(input logic [IDX_W-1:0] i);
    return (ADDR_WIDTH'(i) << BYTE_SHIFT) & ADDR_MASK;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] lfsr_addr(input logic [31:0] v);
    return ADDR_WIDTH'(v) & ADDR_MASK;
  endfunction

  always_comb begin
    in_txn   = (state_q != StIdle) && (state_q != StDone);
    go       = start && !in_txn;
    accept   = ((state_q == StWrReq) || (state_q == StRdReq)) && cmd_rdy;
    last     = (idx_q == LAST_IDX);
    seq      = (mode_q == TG_SEQUENTIAL);
    wr_fin   = (state_q == StWrWait) && (wvalid || pend_q);
    rd_fin   = (state_q == StRdWait) && (rvalid || pend_q);
    // Progress on the final counted cycle beats the timeout.
    tmo_hit  = in_txn && (tmo_q == TMO_LAST) && !(accept || wr_fin || rd_fin);
    rd_word  = pend_q ? rdata_q : rdata;
    mism     = (rd_word != cmd_wdata);
    err_next = (rd_fin && mism && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    // LFSRs step on acceptance so the next word is ready when the current transaction retires.
    addr_load = go;
    addr_step = accept && !seq && (state_q == StRdReq);
    data_load = go || (wr_fin && seq && last);
    data_step = accept && (seq || (state_q == StRdReq));
  end

  sdram_lfsr #(
    .WIDTH(32),
    .POLY (LFSR_POLY32),
    .SEED (ADDR_SEED)
  ) u_addr_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (addr_load),
    .step (addr_step),
    .value(addr_val)
  );

  sdram_lfsr #(
    .WIDTH(32),
    .POLY (LFSR_POLY32),
    .SEED (DATA_SEED)
  ) u_data_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (data_load),
    .step (data_step),
    .value(data_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      mode_q         <= TG_PAIRED;
      idx_q          <= '0;
      tmo_q          <= '0;
      pend_q         <= 1'b0;
      rdata_q        <= '0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
      cmd_wr         <= 1'b0;
      cmd_rd         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      err_count <= err_next;
      if (rd_fin && mism && (err_count == 16'd0)) begin
        first_err_addr <= cmd_addr;
        first_err_data <= rd_word;
      end
      if (in_txn) tmo_q <= tmo_q + 1'b1;

      if (tmo_hit) begin
        state_q <= StDone;
        tmo_q   <= '0;
        cmd_wr  <= 1'b0;
        cmd_rd  <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start) begin
              state_q        <= StWrReq;
              mode_q         <= tg_mode_e'(mode);
              idx_q          <= '0;
              tmo_q          <= '0;
              pend_q         <= 1'b0;
              cmd_addr       <= mode ? seq_addr('0) : lfsr_addr(ADDR_SEED);
              cmd_wdata      <= DATA_WIDTH'(DATA_SEED);
              cmd_wr         <= 1'b1;
              busy           <= 1'b1;
              done           <= 1'b0;
              pass           <= 1'b0;
              timeout        <= 1'b0;
              err_count      <= '0;
              first_err_addr <= '0;
              first_err_data <= '0;
            end
          end
          StWrReq: begin
            if (cmd_rdy) begin
              state_q <= StWrWait;
              tmo_q   <= '0;
              cmd_wr  <= 1'b0;
              pend_q  <= wvalid;
            end
          end
          StWrWait: begin
            if (wr_fin) begin
              pend_q <= 1'b0;
              tmo_q  <= '0;
              if (!seq) begin
                state_q <= StRdReq;
                cmd_rd  <= 1'b1;
              end else if (last) begin
                state_q   <= StRdReq;
                cmd_rd    <= 1'b1;
                idx_q     <= '0;
                cmd_addr  <= seq_addr('0);
                cmd_wdata <= DATA_WIDTH'(DATA_SEED);
              end else begin
                state_q   <= StWrReq;
                cmd_wr    <= 1'b1;
                idx_q     <= idx_q + 1'b1;
                cmd_addr  <= seq_addr(idx_q + 1'b1);
                cmd_wdata <= DATA_WIDTH'(data_val);
              end
            end
          end
          StRdReq: begin
            if (cmd_rdy) begin
              state_q <= StRdWait;
              tmo_q   <= '0;
              cmd_rd  <= 1'b0;
              pend_q  <= rvalid;
              rdata_q <= rdata;
            end
          end
          StRdWait: begin
            if (rd_fin) begin
              pend_q <= 1'b0;
              tmo_q  <= '0;
              if (last) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= (err_next == 16'd0);
              end else begin
                idx_q     <= idx_q + 1'b1;
                cmd_wdata <= DATA_WIDTH'(data_val);
                if (seq) begin
                  state_q  <= StRdReq;
                  cmd_rd   <= 1'b1;
                  cmd_addr <= seq_addr(idx_q + 1'b1);
                end else begin
                  state_q  <= StWrReq;
                  cmd_wr   <= 1'b1;
                  cmd_addr <= lfsr_addr(addr_val);
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
